mem_stage_s4: RTL and testbench
===============================

// Module: mem_stage_s4
// PURPOSE
//  Stage-4 memory-access controller; it feeds the S4/S5 pipeline register.
//  Non-memory ops pass straight through to S5 in one cycle.
//  Loads and stores run a req/gnt/rvalid handshake with data memory, stall
//  upstream until done, then present the aligned, extended result plus its
//  rd/flags/funct3 to S5 with a one-cycle s5_valid (the S4/S5 enable).
//  It also flags misaligned/illegal accesses and memory timeouts.
// PARAMETERS
//  MAX_WAIT   255  cycles in REQ+WAIT before timeout_err (range 2..65535)
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   asynchronous reset, active-high
//  valid_in       in   1   S3 presents an op (inputs stable while stall_out=1)
//  flush_in       in   1   squash op in flight
//  alu_result_in  in   32  ALU result / effective address
//  store_data_in  in   32  rs2 store data
//  rd_in          in   5   destination register
//  instr_flags_in in   7   [0]reg_write [1]mem_read [2]mem_write [6:3]passthrough
//  funct3_in      in   3   access size/sign
//  stall_out      out  1   hold S3 and earlier stages
//  dmem_req       out  1   memory request, held until dmem_gnt
//  dmem_we        out  1   1=store
//  dmem_addr      out  32  word-aligned address {addr[31:2],2'b00}
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_be        out  4   byte enables
//  dmem_gnt       in   1   request accepted
//  dmem_rvalid    in   1   load data valid / store ack
//  dmem_rdata     in   32  load word
//  s5_valid       out  1   S4/S5 latch enable
//  s5_result      out  32  ALU result or extended load data
//  s5_rd          out  5   to latch rd_in
//  s5_flags       out  7   to latch instr_flags_in
//  s5_funct3      out  3   to latch funct3_in
//  misalign_err   out  1   one-cycle pulse
//  timeout_err    out  1   one-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE; op regs, rsp_q and wait counter cleared. All outputs 0
//   while rst=1. dmem_req falls asynchronously with rst. A reset mid-access
//   abandons it.
//  IDLE, valid_in & !flush_in & !(flags[1]|flags[2]): combinational pass-through.
//   s5_valid=1 and s5_*=inputs in the same cycle; stall_out=0.
//  IDLE, valid_in & load/store: capture op into regs; stall_out=1.
//   Illegal funct3 or misalignment -> ERR; otherwise -> REQ.
//   Load funct3 legal = {000,001,010,100,101}; store funct3 legal = {000,001,010}.
//   Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//  REQ: dmem_req=1. dmem_gnt -> WAIT. flush_in (before gnt) -> IDLE with no s5_valid.
//  WAIT: dmem_rvalid is sampled only here; rvalid is never asserted in the gnt cycle.
//   On rvalid, latch extended data into rsp_q and go to DONE.
//   flush_in in WAIT sets a drop bit: the FSM still waits for rvalid, then
//   returns to IDLE with s5_valid=0.
//  DONE (one cycle): s5_valid=1, stall_out=0; -> IDLE.
//   s5_result = rsp_q for loads; the captured address for stores.
//  ERR (one cycle): error pulse, s5_valid=1, s5_flags[0]=0, s5_result=0; -> IDLE.
//  stall_out=1 in every state except IDLE and DONE/ERR.
//  Latency: accept at T; REQ from T+1; gnt at G; WAIT from G+1; rvalid at R;
//   DONE at R+1. Zero-wait memory gives 3 stall cycles.
//  Timeout: a 16-bit counter runs in REQ+WAIT. Reaching MAX_WAIT gives
//   timeout_err plus ERR behaviour. A REQ timeout deasserts dmem_req.
//   A late rvalid arriving in IDLE is ignored.
//  Store: dmem_be = 0001<<a (SB), 0011<<a (SH), 1111 (SW), where a=addr[1:0].
//   dmem_wdata = byte x4 (SB), half x2 (SH), word (SW).
//  Load: select lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend;
//   LW passes the word. rsp_q is 32 bits.
//  dmem_addr, dmem_we, dmem_be and dmem_wdata come from op regs and stay stable
//   through REQ.
//  valid_in while stall_out=1 is ignored; upstream holds the op.
// TESTING
//  ALU op, flags=7'h01, alu=0x1234, rd=5 -> same cycle s5_valid=1, s5_result=0x1234, s5_rd=5, dmem_req=0.
//  LB addr 0x103, rdata 0x80FF_FF7F, gnt +2, rvalid +3 -> result 0xFFFF_FF80.
//   Same with LBU -> 0x0000_0080. stall_out is 1 from accept until DONE.
//  SH addr 0x2, data 0x0000_ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, dmem_addr=0x0.
//  LW addr 0x5 -> no dmem_req; misalign_err pulse; s5_valid=1 with flags[0]=0 and result 0.
//   funct3=011 load -> same response.
//  MAX_WAIT=8, gnt but no rvalid -> timeout_err 8 cycles after REQ entry; FSM back in IDLE.
//  flush_in in WAIT, then rvalid -> s5_valid stays 0.
//   rst pulse in REQ -> dmem_req=0 during rst; state IDLE after release.

Source files
------------

// File: rtl/mem_stage_s4.sv
// mem_stage_s4 - stage-4 memory-access controller feeding the S4/S5 register.
//
// Non-memory ops pass combinationally to S5 in the same cycle. Loads and
// stores are captured into op registers and run a req/gnt/rvalid handshake
// with data memory while upstream is stalled. The aligned/extended result is
// presented to S5 with a one-cycle s5_valid. Misaligned or illegal accesses
// and memory timeouts produce a one-cycle error pulse with a squashed
// reg_write.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   valid_in, flush_in       S3 op valid; squash of the op in flight
//   alu_result_in            ALU result / effective address
//   store_data_in            rs2 store data
//   rd_in, instr_flags_in    destination reg; [0]reg_write [1]mem_read
//                            [2]mem_write [6:3]passthrough
//   funct3_in                access size/sign
//   stall_out                hold S3 and earlier stages
//   dmem_req/we/addr/wdata/be  data-memory request (req held until gnt)
//   dmem_gnt/rvalid/rdata    data-memory accept / response
//   s5_valid, s5_result, s5_rd, s5_flags, s5_funct3   S4/S5 latch contents
//   misalign_err, timeout_err  one-cycle error pulses
module mem_stage_s4 #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        flush_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic [6:0]  instr_flags_in,
  input  logic [2:0]  funct3_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        s5_valid,
  output logic [31:0] s5_result,
  output logic [4:0]  s5_rd,
  output logic [6:0]  s5_flags,
  output logic [2:0]  s5_funct3,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  state_t      state, state_nx;
  logic [31:0] op_addr, op_sdata, rsp_q;
  logic [4:0]  op_rd;
  logic [6:0]  op_flags;
  logic [2:0]  op_funct3;
  logic [15:0] wait_cnt;
  logic        drop_q;  // op was flushed after gnt; finish handshake silently
  logic        tmo_q;   // ERR entered via timeout rather than bad access

  logic        mem_op, accept, in_legal, in_misalign, wait_limit;
  logic [31:0] shifted, load_ext;

  assign mem_op = instr_flags_in[1] | instr_flags_in[2];
  assign accept = (state == S_IDLE) & valid_in & ~flush_in & mem_op;

  // Legal sizes are byte/half/word; the unsigned forms exist only for loads.
  assign in_legal    = (funct3_in[1:0] != 2'b11) &
                       ~(funct3_in[2] & (instr_flags_in[2] | funct3_in[1]));
  assign in_misalign = ((funct3_in[1:0] == 2'b01) & alu_result_in[0]) |
                       ((funct3_in[1:0] == 2'b10) & (alu_result_in[1:0] != 2'b00));
  // >= so a gnt landing on the final REQ cycle still times out in WAIT.
  assign wait_limit  = (wait_cnt >= WAIT_LIMIT);

  assign shifted = dmem_rdata >> {op_addr[1:0], 3'b000};

  always_comb begin
    case (op_funct3)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (in_legal & ~in_misalign) ? S_REQ : S_ERR;
      S_REQ: begin
        if (dmem_gnt)        state_nx = S_WAIT;
        else if (flush_in)   state_nx = S_IDLE;
        else if (wait_limit) state_nx = S_ERR;
      end
      S_WAIT: begin
        if (dmem_rvalid)     state_nx = (drop_q | flush_in) ? S_IDLE : S_DONE;
        else if (wait_limit) state_nx = S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_addr   <= '0;
      op_sdata  <= '0;
      op_rd     <= '0;
      op_flags  <= '0;
      op_funct3 <= '0;
      rsp_q     <= '0;
      wait_cnt  <= '0;
      drop_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_addr   <= alu_result_in;
            op_sdata  <= store_data_in;
            op_rd     <= rd_in;
            op_flags  <= instr_flags_in;
            op_funct3 <= funct3_in;
            wait_cnt  <= '0;
            drop_q    <= 1'b0;
            tmo_q     <= 1'b0;
          end
        end
        S_REQ, S_WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          tmo_q    <= (state_nx == S_ERR);
          if (flush_in) drop_q <= 1'b1;
          if (state == S_WAIT && dmem_rvalid) rsp_q <= load_ext;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_out    = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    dmem_be      = '0;
    s5_valid     = 1'b0;
    s5_result    = '0;
    s5_rd        = '0;
    s5_flags     = '0;
    s5_funct3    = '0;
    misalign_err = 1'b0;
    timeout_err  = 1'b0;
    if (!rst) begin
      dmem_we   = op_flags[2];
      dmem_addr = {op_addr[31:2], 2'b00};
      case (op_funct3[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << op_addr[1:0];
          dmem_wdata = {4{op_sdata[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << op_addr[1:0];
          dmem_wdata = {2{op_sdata[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = op_sdata;
        end
      endcase
      case (state)
        S_IDLE: begin
          if (valid_in && !flush_in) begin
            if (mem_op) begin
              stall_out = 1'b1;
            end else begin
              s5_valid  = 1'b1;
              s5_result = alu_result_in;
              s5_rd     = rd_in;
              s5_flags  = instr_flags_in;
              s5_funct3 = funct3_in;
            end
          end
        end
        S_REQ: begin
          stall_out = 1'b1;
          dmem_req  = 1'b1;
        end
        S_WAIT: stall_out = 1'b1;
        S_DONE: begin
          s5_valid  = 1'b1;
          s5_result = op_flags[2] ? op_addr : rsp_q;
          s5_rd     = op_rd;
          s5_flags  = op_flags;
          s5_funct3 = op_funct3;
        end
        S_ERR: begin
          s5_valid     = ~drop_q;
          s5_rd        = op_rd;
          s5_flags     = {op_flags[6:1], 1'b0};
          s5_funct3    = op_funct3;
          misalign_err = ~tmo_q;
          timeout_err  = tmo_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_s4.sv
// tb_mem_stage_s4 - self-checking bench for mem_stage_s4 (MAX_WAIT=8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge. Expected values come from byte-level reference
// functions below.
module tb_mem_stage_s4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, flush_in;
  logic [31:0] alu_result_in, store_data_in;
  logic [4:0]  rd_in;
  logic [6:0]  instr_flags_in;
  logic [2:0]  funct3_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        s5_valid;
  logic [31:0] s5_result;
  logic [4:0]  s5_rd;
  logic [6:0]  s5_flags;
  logic [2:0]  s5_funct3;
  logic        misalign_err, timeout_err;

  int checks = 0;
  int failures = 0;

  mem_stage_s4 #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush_in(flush_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .rd_in(rd_in), .instr_flags_in(instr_flags_in), .funct3_in(funct3_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .s5_valid(s5_valid), .s5_result(s5_result), .s5_rd(s5_rd),
    .s5_flags(s5_flags), .s5_funct3(s5_funct3),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit legal_f(bit st, logic [2:0] f3);
    if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int nbytes(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit misal_f(logic [2:0] f3, logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(logic [2:0] f3, logic [31:0] addr);
    logic [3:0] be;
    int a = int'(addr % 4);
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + n);
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] d);
    logic [31:0] w;
    int n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rd);
    logic [31:0] v = '0;
    int a = int'(addr % 4);
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(a+i) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic idle_inputs();
    valid_in = 0; flush_in = 0; dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; idle_inputs();
    valid_in = 1; instr_flags_in = 7'h01; alu_result_in = $urandom; rd_in = 5'd3;
    funct3_in = 3'd0; store_data_in = '0; dmem_rdata = '0;
    @(negedge clk);
    checks++; if (s5_valid !== 1'b0) begin failures++; $display("FAIL reset_s5_valid got=%b want=0", s5_valid); end
    checks++; if (s5_result !== 32'd0) begin failures++; $display("FAIL reset_s5_result got=%h want=0", s5_result); end
    checks++; if ({stall_out, dmem_req, misalign_err, timeout_err} !== 4'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b want=0000", {stall_out, dmem_req, misalign_err, timeout_err}); end
    @(negedge clk);
    rst = 0; valid_in = 0;
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd, input logic [6:0] fl, input logic [2:0] f3);
    @(posedge clk); #1;
    valid_in = 1; flush_in = 0; alu_result_in = alu; rd_in = rd; instr_flags_in = fl; funct3_in = f3;
    store_data_in = $urandom;
    @(negedge clk);
    checks++; if (s5_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b want=1", s5_valid); end
    checks++; if ({s5_result, s5_rd, s5_flags, s5_funct3} !== {alu, rd, fl, f3}) begin failures++;
      $display("FAIL alu_fields got=%h/%h/%h/%h want=%h/%h/%h/%h", s5_result, s5_rd, s5_flags, s5_funct3, alu, rd, fl, f3); end
    checks++; if ({stall_out, dmem_req} !== 2'b00) begin failures++; $display("FAIL alu_stall_req got=%b want=00", {stall_out, dmem_req}); end
  endtask

  task automatic test_alu_passthrough();
    alu_op(32'h1234, 5'd5, 7'h01, 3'd0);
    for (int i = 0; i < 8; i++) alu_op($urandom, 5'($urandom), 7'($urandom) & 7'h79, 3'($urandom));
    @(posedge clk); #1; valid_in = 0;
    @(negedge clk);
    checks++; if (s5_valid !== 1'b0) begin failures++; $display("FAIL alu_idle_valid got=%b want=0", s5_valid); end
  endtask

  task automatic run_mem(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int g, input int r);
    logic [6:0]  fl;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    bit          bad, done;
    int          stalls;
    fl = {4'($urandom), st, !st, !st};
    rd = 5'($urandom);
    bad = !legal_f(st, f3) || misal_f(f3, addr);
    exp_res = st ? addr : exp_load(f3, addr, rdata);
    @(posedge clk); #1;
    valid_in = 1; flush_in = 0; alu_result_in = addr; store_data_in = sdata; rd_in = rd;
    instr_flags_in = fl; funct3_in = f3; dmem_gnt = 0; dmem_rvalid = 0;
    @(negedge clk);
    checks++; if ({stall_out, dmem_req, s5_valid} !== 3'b100) begin failures++;
      $display("FAIL accept_ctrl got=%b want=100", {stall_out, dmem_req, s5_valid}); end
    if (bad) begin
      @(posedge clk); #1; valid_in = 0;
      @(negedge clk);
      checks++; if ({misalign_err, timeout_err, s5_valid, dmem_req, stall_out} !== 5'b10100) begin failures++;
        $display("FAIL err_ctrl got=%b want=10100", {misalign_err, timeout_err, s5_valid, dmem_req, stall_out}); end
      checks++; if ({s5_result, s5_flags, s5_rd, s5_funct3} !== {32'd0, fl[6:1], 1'b0, rd, f3}) begin failures++;
        $display("FAIL err_fields got=%h/%h/%h/%h want=0/%h/%h/%h", s5_result, s5_flags, s5_rd, s5_funct3,
                 {fl[6:1], 1'b0}, rd, f3); end
    end else begin
      stalls = 1; done = 0;
      for (int c = 1; c <= 40 && !done; c++) begin
        @(posedge clk); #1;
        dmem_gnt    = (c == g + 1);
        dmem_rvalid = (c == g + 1 + r);
        dmem_rdata  = (c == g + 1 + r) ? rdata : $urandom;
        valid_in    = (c <= g + 1 + r);
        @(negedge clk);
        if (c <= g + 1) begin
          checks++; if ({dmem_req, stall_out, s5_valid} !== 3'b110) begin failures++;
            $display("FAIL req_phase c=%0d got=%b want=110", c, {dmem_req, stall_out, s5_valid}); end
          checks++; if ({dmem_addr, dmem_we} !== {addr[31:2], 2'b00, st}) begin failures++;
            $display("FAIL req_addr got=%h/%b want=%h/%b", dmem_addr, dmem_we, {addr[31:2], 2'b00}, st); end
          if (st) begin
            checks++; if ({dmem_be, dmem_wdata} !== {exp_be(f3, addr), exp_wdata(f3, sdata)}) begin failures++;
              $display("FAIL store_lanes got=%b/%h want=%b/%h", dmem_be, dmem_wdata, exp_be(f3, addr), exp_wdata(f3, sdata)); end
          end
        end else if (c <= g + 1 + r) begin
          checks++; if ({dmem_req, stall_out, s5_valid} !== 3'b010) begin failures++;
            $display("FAIL wait_phase c=%0d got=%b want=010", c, {dmem_req, stall_out, s5_valid}); end
        end else begin
          done = 1;
          checks++; if ({s5_valid, stall_out, misalign_err, timeout_err} !== 4'b1000) begin failures++;
            $display("FAIL done_ctrl got=%b want=1000", {s5_valid, stall_out, misalign_err, timeout_err}); end
          checks++; if (s5_result !== exp_res) begin failures++;
            $display("FAIL done_result f3=%0d addr=%h got=%h want=%h", f3, addr, s5_result, exp_res); end
          checks++; if ({s5_rd, s5_flags, s5_funct3} !== {rd, fl, f3}) begin failures++;
            $display("FAIL done_fields got=%h/%h/%h want=%h/%h/%h", s5_rd, s5_flags, s5_funct3, rd, fl, f3); end
        end
        if (stall_out) stalls++;
      end
      checks++; if (!done) begin failures++; $display("FAIL done_timeout got=no DONE want=DONE within 40 cycles"); end
      checks++; if (stalls != g + r + 2) begin failures++; $display("FAIL stall_count got=%0d want=%0d", stalls, g + r + 2); end
    end
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    checks++; if ({s5_valid, misalign_err, timeout_err, stall_out, dmem_req} !== 5'b0) begin failures++;
      $display("FAIL post_idle got=%b want=00000", {s5_valid, misalign_err, timeout_err, stall_out, dmem_req}); end
  endtask

  task automatic test_directed_mem();
    run_mem(0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 2, 3);  // LB
    run_mem(0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 2, 3);  // LBU
    run_mem(1, 3'b001, 32'h0000_0002, 32'h0000_ABCD, 32'h0, 0, 1);  // SH
    run_mem(0, 3'b010, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 0, 1);  // LW, zero-wait
    run_mem(0, 3'b010, 32'h0000_0005, 32'h0, 32'h0, 0, 1);          // LW misaligned
    run_mem(0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 1);          // illegal load
    run_mem(1, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 0, 1);          // illegal store
    run_mem(0, 3'b101, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 1, 2);  // LHU upper half
    run_mem(0, 3'b001, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 1, 2);  // LH upper half
  endtask

  task automatic test_timeout();
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      valid_in = 1; flush_in = 0; alu_result_in = 32'h40; rd_in = 5'd7;
      instr_flags_in = 7'h03; funct3_in = 3'b010;
      for (int c = 1; c <= 9; c++) begin
        @(posedge clk); #1;
        dmem_gnt = (v == 1) && (c == 1);
        @(negedge clk);
        if (c <= 8) begin
          checks++; if ({timeout_err, stall_out, dmem_req} !== {2'b01, (v == 0) || (c == 1)}) begin failures++;
            $display("FAIL tmo_wait v=%0d c=%0d got=%b want=%b", v, c, {timeout_err, stall_out, dmem_req},
                     {2'b01, (v == 0) || (c == 1)}); end
        end else begin
          checks++; if ({timeout_err, misalign_err, s5_valid, dmem_req, stall_out} !== 5'b10100) begin failures++;
            $display("FAIL tmo_err v=%0d got=%b want=10100", v, {timeout_err, misalign_err, s5_valid, dmem_req, stall_out}); end
          checks++; if ({s5_result, s5_flags} !== {32'd0, 7'h02}) begin failures++;
            $display("FAIL tmo_fields v=%0d got=%h/%h want=0/02", v, s5_result, s5_flags); end
        end
      end
      @(posedge clk); #1;
      idle_inputs(); dmem_rvalid = 1; dmem_rdata = $urandom;  // late response
      @(negedge clk);
      checks++; if ({s5_valid, stall_out, timeout_err, dmem_req} !== 4'b0) begin failures++;
        $display("FAIL tmo_late_rvalid v=%0d got=%b want=0000", v, {s5_valid, stall_out, timeout_err, dmem_req}); end
      @(posedge clk); #1; dmem_rvalid = 0;
    end
  endtask

  task automatic test_flush();
    // flush while waiting for rvalid
    @(posedge clk); #1;
    valid_in = 1; flush_in = 0; alu_result_in = 32'h80; rd_in = 5'd9; instr_flags_in = 7'h03; funct3_in = 3'b010;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      dmem_gnt = (c == 1); flush_in = (c == 2); dmem_rvalid = (c == 4); dmem_rdata = $urandom;
      if (c >= 2) valid_in = 0;
      @(negedge clk);
      checks++; if (s5_valid !== 1'b0) begin failures++; $display("FAIL flush_wait_valid c=%0d got=%b want=0", c, s5_valid); end
      checks++; if (stall_out !== (c <= 4)) begin failures++; $display("FAIL flush_wait_stall c=%0d got=%b want=%b", c, stall_out, c <= 4); end
    end
    idle_inputs();
    // flush before gnt
    @(posedge clk); #1;
    valid_in = 1; alu_result_in = 32'h84; instr_flags_in = 7'h05; funct3_in = 3'b010;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      flush_in = (c == 2);
      if (c >= 2) valid_in = 0;
      @(negedge clk);
      checks++; if ({dmem_req, stall_out, s5_valid} !== ((c <= 2) ? 3'b110 : 3'b000)) begin failures++;
        $display("FAIL flush_req c=%0d got=%b want=%b", c, {dmem_req, stall_out, s5_valid}, (c <= 2) ? 3'b110 : 3'b000); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_req();
    @(posedge clk); #1;
    valid_in = 1; alu_result_in = 32'h90; rd_in = 5'd2; instr_flags_in = 7'h03; funct3_in = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rstreq_pre got=%b want=1", dmem_req); end
    #2 rst = 1;
    #1;
    checks++; if ({dmem_req, stall_out} !== 2'b00) begin failures++; $display("FAIL rstreq_async got=%b want=00", {dmem_req, stall_out}); end
    @(posedge clk); #1; valid_in = 0;
    @(negedge clk); rst = 0;
    alu_op(32'hCAFE_F00D, 5'd11, 7'h09, 3'd3);
    @(posedge clk); #1; idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        alu_op($urandom, 5'($urandom), 7'($urandom) & 7'h79, 3'($urandom));
      end else begin
        bit          st = 1'($urandom);
        logic [2:0]  f3 = 3'($urandom);
        logic [31:0] a = $urandom;
        if ($urandom_range(0, 1) == 1) a = a & ~32'(nbytes(f3) - 1);
        run_mem(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
      end
    end
    @(posedge clk); #1; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_directed_mem();
    test_timeout();
    test_flush();
    test_reset_in_req();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
